// File: rtl/password_mem_arbiter.sv
// Shares the password store memory port between the access-check FSM (port 0)
// and the password-update path (port 1); one transaction in flight at a time.
module password_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam int              CNT_W    = 3;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sel_q, sel_d;    // port owning the current transaction
  logic              we_q, we_d;
  logic              prio_q, prio_d;  // port favoured when both request
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic              pick;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    we_d        = we_q;
    prio_d      = prio_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    rvalid0_d   = 1'b0;
    rvalid1_d   = 1'b0;
    pick        = req1;
    if (req0 && req1) pick = prio_q;

    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          sel_d       = pick;
          we_d        = pick ? we1 : we0;
          mem_addr_d  = pick ? addr1 : addr0;
          mem_wdata_d = pick ? wdata1 : wdata0;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        prio_d = ~sel_q;
        if (we_q) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d   = CNT_LOAD;
          state_d = (RD_LAT > 1) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_RESP;
      end
      ST_RESP: begin
        // Data is valid now; the owner sees rvalid in the following IDLE cycle.
        rdata_d   = mem_rdata;
        rvalid0_d = ~sel_q;
        rvalid1_d = sel_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sel_q       <= 1'b0;
      we_q        <= 1'b0;
      prio_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      prio_q      <= prio_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
    end
  end

  assign gnt0      = (state_q == ST_ISSUE) && !sel_q;
  assign gnt1      = (state_q == ST_ISSUE) && sel_q;
  assign mem_wren  = (state_q == ST_ISSUE) && we_q;
  assign busy      = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign rvalid0   = rvalid0_q;
  assign rvalid1   = rvalid1_q;
  assign rdata     = rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_password_mem_arbiter.sv
// Bench for password_mem_arbiter: two instances (read latency 1 and 3), each
// with its own memory model, checked by directed scenarios and a random run.
module tb_password_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;

  logic clk;
  logic rst;

  logic          req0_s [2], we0_s [2], req1_s [2], we1_s [2];
  logic [AW-1:0] addr0_s [2], addr1_s [2];
  logic [DW-1:0] wdata0_s [2], wdata1_s [2];
  logic          gnt0_s [2], gnt1_s [2], rvalid0_s [2], rvalid1_s [2];
  logic          mem_wren_s [2], busy_s [2];
  logic [DW-1:0] rdata_s [2], mwdata_s [2], mrdata_s [2];
  logic [AW-1:0] maddr_s [2];

  logic [DW-1:0] mem [2][256];
  logic [DW-1:0] pipe [2][3];
  logic [DW-1:0] ref_mem [2][256];

  int n_cmp  = 0;
  int n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  password_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u_dut_l1 (
    .clk(clk), .rst(rst),
    .req0(req0_s[0]), .we0(we0_s[0]), .addr0(addr0_s[0]), .wdata0(wdata0_s[0]),
    .gnt0(gnt0_s[0]), .rvalid0(rvalid0_s[0]),
    .req1(req1_s[0]), .we1(we1_s[0]), .addr1(addr1_s[0]), .wdata1(wdata1_s[0]),
    .gnt1(gnt1_s[0]), .rvalid1(rvalid1_s[0]),
    .rdata(rdata_s[0]), .mem_addr(maddr_s[0]), .mem_wdata(mwdata_s[0]),
    .mem_wren(mem_wren_s[0]), .mem_rdata(mrdata_s[0]), .busy(busy_s[0])
  );

  password_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) u_dut_l3 (
    .clk(clk), .rst(rst),
    .req0(req0_s[1]), .we0(we0_s[1]), .addr0(addr0_s[1]), .wdata0(wdata0_s[1]),
    .gnt0(gnt0_s[1]), .rvalid0(rvalid0_s[1]),
    .req1(req1_s[1]), .we1(we1_s[1]), .addr1(addr1_s[1]), .wdata1(wdata1_s[1]),
    .gnt1(gnt1_s[1]), .rvalid1(rvalid1_s[1]),
    .rdata(rdata_s[1]), .mem_addr(maddr_s[1]), .mem_wdata(mwdata_s[1]),
    .mem_wren(mem_wren_s[1]), .mem_rdata(mrdata_s[1]), .busy(busy_s[1])
  );

  // Synchronous memories: instance 0 returns data one cycle after the address, instance 1 three.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mem_wren_s[i]) mem[i][maddr_s[i][7:0]] <= mwdata_s[i];
      pipe[i][0] <= mem[i][maddr_s[i][7:0]];
      pipe[i][1] <= pipe[i][0];
      pipe[i][2] <= pipe[i][1];
    end
  end
  assign mrdata_s[0] = pipe[0][0];
  assign mrdata_s[1] = pipe[1][2];

  function automatic int lat_of(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // {gnt0, gnt1, rvalid0, rvalid1, mem_wren, busy}
  function automatic logic [5:0] flags(int k);
    return {gnt0_s[k], gnt1_s[k], rvalid0_s[k], rvalid1_s[k], mem_wren_s[k], busy_s[k]};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < 2; k++) begin
      req0_s[k] = 1'b0; we0_s[k] = 1'b0; addr0_s[k] = '0; wdata0_s[k] = '0;
      req1_s[k] = 1'b0; we1_s[k] = 1'b0; addr1_s[k] = '0; wdata1_s[k] = '0;
    end
  endtask

  task automatic do_reset();
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({flags(k), rdata_s[k], maddr_s[k], mwdata_s[k]} !== 54'h0) begin
        n_fail++;
        $display("FAIL reset_outputs inst%0d: got %h expected 0", k,
                 {flags(k), rdata_s[k], maddr_s[k], mwdata_s[k]});
      end
    end
    @(negedge clk);
    rst = 1'b1;
    step();
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (flags(k) !== 6'b000000) begin
        n_fail++;
        $display("FAIL reset_idle inst%0d: flags %b expected 000000", k, flags(k));
      end
    end
  endtask

  task automatic test_read_basic();
    step();
    req0_s[0] = 1'b1; we0_s[0] = 1'b0; addr0_s[0] = 16'h0002;
    step();
    n_cmp++;
    if ({flags(0), maddr_s[0]} !== {6'b100001, 16'h0002}) begin
      n_fail++;
      $display("FAIL read_grant: flags/addr %b/%h expected 100001/0002", flags(0), maddr_s[0]);
    end
    req0_s[0] = 1'b0;
    step();
    n_cmp++;
    if (flags(0) !== 6'b000000) begin
      n_fail++;
      $display("FAIL read_resp_cycle: flags %b expected 000000", flags(0));
    end
    step();
    n_cmp++;
    if ({flags(0), rdata_s[0]} !== {6'b001000, 16'h1234}) begin
      n_fail++;
      $display("FAIL read_rvalid: flags/rdata %b/%h expected 001000/1234", flags(0), rdata_s[0]);
    end
    step();
    n_cmp++;
    if (flags(0) !== 6'b000000) begin
      n_fail++;
      $display("FAIL read_rvalid_pulse: flags %b expected 000000", flags(0));
    end
  endtask

  task automatic test_write();
    req1_s[0] = 1'b1; we1_s[0] = 1'b1; addr1_s[0] = 16'h0001; wdata1_s[0] = 16'hBEEF;
    step();
    n_cmp++;
    if ({flags(0), maddr_s[0], mwdata_s[0]} !== {6'b010011, 16'h0001, 16'hBEEF}) begin
      n_fail++;
      $display("FAIL write_issue: flags/addr/wdata %b/%h/%h expected 010011/0001/beef",
               flags(0), maddr_s[0], mwdata_s[0]);
    end
    req1_s[0] = 1'b0;
    ref_mem[0][1] = 16'hBEEF;
    for (int i = 1; i <= 2; i++) begin
      step();
      n_cmp++;
      if (flags(0) !== 6'b000000) begin
        n_fail++;
        $display("FAIL write_after T+%0d: flags %b expected 000000", i, flags(0));
      end
    end
    req1_s[0] = 1'b1; we1_s[0] = 1'b0;
    step();
    n_cmp++;
    if (flags(0) !== 6'b010001) begin
      n_fail++;
      $display("FAIL readback_grant: flags %b expected 010001", flags(0));
    end
    req1_s[0] = 1'b0;
    step();
    step();
    n_cmp++;
    if ({flags(0), rdata_s[0]} !== {6'b000100, 16'hBEEF}) begin
      n_fail++;
      $display("FAIL readback_data: flags/rdata %b/%h expected 000100/beef", flags(0), rdata_s[0]);
    end
  endtask

  task automatic test_alternate();
    int ng, nr;
    logic [1:0] exp_g;
    logic [DW-1:0] exp_d;
    ng = 0; nr = 0;
    do_reset();
    req0_s[0] = 1'b1; we0_s[0] = 1'b0; addr0_s[0] = 16'h0004;
    req1_s[0] = 1'b1; we1_s[0] = 1'b0; addr1_s[0] = 16'h0005;
    for (int cyc = 0; cyc < 60 && (ng < 4 || nr < 4); cyc++) begin
      step();
      if (gnt0_s[0] || gnt1_s[0]) begin
        exp_g = (ng % 2 == 1) ? 2'b01 : 2'b10;
        n_cmp++;
        if ({gnt0_s[0], gnt1_s[0]} !== exp_g) begin
          n_fail++;
          $display("FAIL alt_grant #%0d: gnt %b expected %b", ng, {gnt0_s[0], gnt1_s[0]}, exp_g);
        end
        ng++;
        if (ng == 4) begin req0_s[0] = 1'b0; req1_s[0] = 1'b0; end
      end
      if (rvalid0_s[0] || rvalid1_s[0]) begin
        exp_g = (nr % 2 == 1) ? 2'b01 : 2'b10;
        exp_d = ref_mem[0][(nr % 2 == 1) ? 5 : 4];
        n_cmp++;
        if ({rvalid0_s[0], rvalid1_s[0], rdata_s[0]} !== {exp_g, exp_d}) begin
          n_fail++;
          $display("FAIL alt_rvalid #%0d: rvalid/rdata %b/%h expected %b/%h", nr,
                   {rvalid0_s[0], rvalid1_s[0]}, rdata_s[0], exp_g, exp_d);
        end
        nr++;
      end
    end
    n_cmp++;
    if (ng != 4 || nr != 4) begin
      n_fail++;
      $display("FAIL alt_timeout: grants %0d rvalids %0d expected 4/4", ng, nr);
    end
    req0_s[0] = 1'b0; req1_s[0] = 1'b0;
  endtask

  task automatic test_rdlat3();
    step();
    req0_s[1] = 1'b1; we0_s[1] = 1'b0; addr0_s[1] = 16'h0003;
    step();
    n_cmp++;
    if ({flags(1), maddr_s[1]} !== {6'b100001, 16'h0003}) begin
      n_fail++;
      $display("FAIL lat3_grant: flags/addr %b/%h expected 100001/0003", flags(1), maddr_s[1]);
    end
    req0_s[1] = 1'b0;
    req1_s[1] = 1'b1; we1_s[1] = 1'b0; addr1_s[1] = 16'h0007;
    for (int i = 1; i <= 3; i++) begin
      step();
      n_cmp++;
      if ({flags(1), maddr_s[1]} !== {((i < 3) ? 6'b000001 : 6'b000000), 16'h0003}) begin
        n_fail++;
        $display("FAIL lat3_hold T+%0d: flags/addr %b/%h", i, flags(1), maddr_s[1]);
      end
      req1_s[1] = (i != 1);
    end
    step();
    n_cmp++;
    if ({flags(1), rdata_s[1]} !== {6'b001000, ref_mem[1][3]}) begin
      n_fail++;
      $display("FAIL lat3_rvalid: flags/rdata %b/%h expected 001000/%h", flags(1), rdata_s[1], ref_mem[1][3]);
    end
    step();
    n_cmp++;
    if ({flags(1), maddr_s[1]} !== {6'b010001, 16'h0007}) begin
      n_fail++;
      $display("FAIL lat3_next_grant: flags/addr %b/%h expected 010001/0007", flags(1), maddr_s[1]);
    end
    req1_s[1] = 1'b0;
    repeat (4) step();
    n_cmp++;
    if ({flags(1), rdata_s[1]} !== {6'b000100, ref_mem[1][7]}) begin
      n_fail++;
      $display("FAIL lat3_rvalid1: flags/rdata %b/%h expected 000100/%h", flags(1), rdata_s[1], ref_mem[1][7]);
    end
  endtask

  task automatic test_reset_mid();
    step();
    req0_s[1] = 1'b1; we0_s[1] = 1'b0; addr0_s[1] = 16'h000A;
    step();
    n_cmp++;
    if (flags(1) !== 6'b100001) begin
      n_fail++;
      $display("FAIL rstmid_grant: flags %b expected 100001", flags(1));
    end
    req0_s[1] = 1'b0;
    step();
    #1 rst = 1'b0;
    #1;
    n_cmp++;
    if ({flags(1), rdata_s[1], maddr_s[1], mwdata_s[1]} !== 54'h0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got %h expected 0", {flags(1), rdata_s[1], maddr_s[1], mwdata_s[1]});
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      n_cmp++;
      if (flags(1) !== 6'b000000) begin
        n_fail++;
        $display("FAIL rstmid_quiet cyc%0d: flags %b expected 000000", i, flags(1));
      end
    end
    req0_s[1] = 1'b1; addr0_s[1] = 16'h000B;
    req1_s[1] = 1'b1; we1_s[1] = 1'b0; addr1_s[1] = 16'h000C;
    step();
    n_cmp++;
    if (flags(1) !== 6'b100001) begin
      n_fail++;
      $display("FAIL rstmid_pointer: flags %b expected 100001", flags(1));
    end
    req0_s[1] = 1'b0; req1_s[1] = 1'b0;
    repeat (4) step();
    n_cmp++;
    if ({flags(1), rdata_s[1]} !== {6'b001000, ref_mem[1][11]}) begin
      n_fail++;
      $display("FAIL rstmid_read: flags/rdata %b/%h expected 001000/%h", flags(1), rdata_s[1], ref_mem[1][11]);
    end
  endtask

  task automatic test_withdraw();
    logic [5:0] exp_f;
    step();
    req1_s[1] = 1'b1; we1_s[1] = 1'b0; addr1_s[1] = 16'h0009;
    step();
    n_cmp++;
    if (flags(1) !== 6'b010001) begin
      n_fail++;
      $display("FAIL withdraw_grant1: flags %b expected 010001", flags(1));
    end
    req1_s[1] = 1'b0;
    step();
    req0_s[1] = 1'b1; we0_s[1] = 1'b0; addr0_s[1] = 16'h000D;
    step();
    req0_s[1] = 1'b0;
    for (int i = 3; i <= 10; i++) begin
      step();
      exp_f = (i == 4) ? 6'b000100 : 6'b000000;
      n_cmp++;
      if (flags(1) !== exp_f) begin
        n_fail++;
        $display("FAIL withdraw T+%0d: flags %b expected %b", i, flags(1), exp_f);
      end
      if (i == 4) begin
        n_cmp++;
        if (rdata_s[1] !== ref_mem[1][9]) begin
          n_fail++;
          $display("FAIL withdraw_rdata: got %h expected %h", rdata_s[1], ref_mem[1][9]);
        end
      end
    end
  endtask

  // Model: a grant follows any IDLE cycle with a request; ties go to the port not granted last;
  // a write frees the port one cycle after issue, a read delivers data RD_LAT+1 cycles after issue.
  task automatic test_random(int k);
    int lat, idle_from, last_gnt, rd_port, rd_due, busy_start, busy_end, p;
    logic rd_pend, r0, r1, g_we, exp_busy, exp_wren;
    logic [1:0] exp_g, exp_rv;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wdata, rd_exp;
    lat = lat_of(k);
    idle_from = 0; last_gnt = 1; rd_pend = 1'b0; rd_port = 0; rd_due = 0;
    busy_start = -10; busy_end = -10; rd_exp = '0; p = 0;
    do_reset();
    for (int cyc = 0; cyc < 408; cyc++) begin
      step();
      r0 = req0_s[k]; r1 = req1_s[k];
      exp_g = 2'b00;
      if ((cyc - 1 >= idle_from) && (r0 || r1)) begin
        p = (r0 && r1) ? (1 - last_gnt) : (r1 ? 1 : 0);
        exp_g = (p == 1) ? 2'b01 : 2'b10;
      end
      n_cmp++;
      if ({gnt0_s[k], gnt1_s[k]} !== exp_g) begin
        n_fail++;
        $display("FAIL rnd_gnt inst%0d cyc%0d: gnt %b expected %b", k, cyc, {gnt0_s[k], gnt1_s[k]}, exp_g);
      end
      exp_rv = (rd_pend && cyc == rd_due) ? ((rd_port == 1) ? 2'b01 : 2'b10) : 2'b00;
      n_cmp++;
      if ({rvalid0_s[k], rvalid1_s[k]} !== exp_rv) begin
        n_fail++;
        $display("FAIL rnd_rvalid inst%0d cyc%0d: rvalid %b expected %b", k, cyc,
                 {rvalid0_s[k], rvalid1_s[k]}, exp_rv);
      end
      if (exp_rv != 2'b00) begin
        rd_pend = 1'b0;
        n_cmp++;
        if (rdata_s[k] !== rd_exp) begin
          n_fail++;
          $display("FAIL rnd_rdata inst%0d cyc%0d: got %h expected %h", k, cyc, rdata_s[k], rd_exp);
        end
      end
      exp_wren = 1'b0;
      if (exp_g != 2'b00) begin
        g_we    = (p == 1) ? we1_s[k] : we0_s[k];
        g_addr  = (p == 1) ? addr1_s[k] : addr0_s[k];
        g_wdata = (p == 1) ? wdata1_s[k] : wdata0_s[k];
        exp_wren = g_we;
        n_cmp++;
        if (maddr_s[k] !== g_addr || (g_we && mwdata_s[k] !== g_wdata)) begin
          n_fail++;
          $display("FAIL rnd_issue inst%0d cyc%0d: addr/wdata %h/%h expected %h/%h", k, cyc,
                   maddr_s[k], mwdata_s[k], g_addr, g_wdata);
        end
        last_gnt = p;
        busy_start = cyc;
        if (g_we) begin
          ref_mem[k][g_addr[7:0]] = g_wdata;
          idle_from = cyc + 1;
          busy_end = cyc;
        end else begin
          rd_pend = 1'b1; rd_port = p; rd_due = cyc + lat + 1;
          rd_exp = ref_mem[k][g_addr[7:0]];
          idle_from = cyc + lat + 1;
          busy_end = cyc + lat - 1;
        end
        if (p == 1) req1_s[k] = 1'b0; else req0_s[k] = 1'b0;
      end
      exp_busy = (cyc >= busy_start) && (cyc <= busy_end);
      n_cmp++;
      if ({mem_wren_s[k], busy_s[k]} !== {exp_wren, exp_busy}) begin
        n_fail++;
        $display("FAIL rnd_wren_busy inst%0d cyc%0d: got %b expected %b", k, cyc,
                 {mem_wren_s[k], busy_s[k]}, {exp_wren, exp_busy});
      end
      if (cyc >= 400) begin
        req0_s[k] = 1'b0; req1_s[k] = 1'b0;
      end else begin
        if (!req0_s[k] && !(exp_g == 2'b10) && $urandom_range(1, 0) == 1) begin
          req0_s[k] = 1'b1; we0_s[k] = ($urandom_range(2, 0) == 0);
          addr0_s[k] = AW'($urandom_range(31, 0)); wdata0_s[k] = DW'($urandom);
        end else if (req0_s[k] && $urandom_range(19, 0) == 0) begin
          req0_s[k] = 1'b0;
        end
        if (!req1_s[k] && !(exp_g == 2'b01) && $urandom_range(1, 0) == 1) begin
          req1_s[k] = 1'b1; we1_s[k] = ($urandom_range(2, 0) == 0);
          addr1_s[k] = AW'($urandom_range(31, 0)); wdata1_s[k] = DW'($urandom);
        end else if (req1_s[k] && $urandom_range(19, 0) == 0) begin
          req1_s[k] = 1'b0;
        end
      end
    end
    n_cmp++;
    if (rd_pend) begin
      n_fail++;
      $display("FAIL rnd_timeout inst%0d: read response still outstanding", k);
    end
  endtask

  initial begin
    logic [DW-1:0] v;
    rst = 1'b1;
    clear_inputs();
    for (int a = 0; a < 256; a++) begin
      for (int i = 0; i < 2; i++) begin
        v = DW'($urandom);
        if (a == 2) v = 16'h1234;
        mem[i][a] <= v;
        ref_mem[i][a] = v;
      end
    end
    test_reset();
    test_read_basic();
    test_write();
    test_alternate();
    test_rdlat3();
    test_reset_mid();
    test_withdraw();
    test_random(0);
    test_random(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
